// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor controller: state encoding
// and the default operand width.
package sub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } sub_state_t;

endpackage

// File: rtl/Half_Subractor.sv
// One-bit half subtractor cell: diff = a - b, borrow set when a < b.
module Half_Subractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor x - y - bin, built from two half-subtractor cells
// so the serial and combinational subtractors share the same verified cell.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  Half_Subractor u_hs0 (
    .a      (x),
    .b      (y),
    .diff   (d1),
    .borrow (b1)
  );

  Half_Subractor u_hs1 (
    .a      (d1),
    .b      (bin),
    .diff   (d),
    .borrow (b2)
  );

  assign bo = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock LSB first,
// sequenced by a start/busy/done handshake with a registered result.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state_q;
  sub_state_t       state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             bor;
  logic             slice_d;
  logic             slice_bo;
  logic             last_bit;

  full_subtractor_bit u_slice (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (bor),
    .d   (slice_d),
    .bo  (slice_bo)
  );

  assign last_bit = (cnt == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so start never reaches them combinationally.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      cnt        <= '0;
      bor        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {slice_d, res_sh[WIDTH-1:1]};
          bor    <= slice_bo;
          // Counter parks at the last index rather than wrapping past WIDTH-1.
          if (last_bit) begin
            diff       <= {slice_d, res_sh[WIDTH-1:1]};
            borrow_out <= slice_bo;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8: handshake timing, results,
// ignored mid-run starts, asynchronous abort and back-to-back operation.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int n_checks;
  int n_fail;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation from IDLE; optionally pulses a second start with new
  // operands at RUN cycle inject_at (1-based, 0 = none).
  task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                    input logic [7:0] exp_d, input logic exp_b, input int inject_at);
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    logic [7:0]  prev_d;
    logic        prev_b;
    logic [7:0]  mid_d;
    logic        mid_b;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    prev_d   = diff;
    prev_b   = borrow_out;
    mid_d    = 8'h00;
    mid_b    = 1'b0;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= WIDTH + 3; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == WIDTH) begin
        mid_d = diff;
        mid_b = borrow_out;
      end
      if (inject_at != 0 && i == inject_at) begin
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
      end
      if (inject_at != 0 && i == inject_at + 1) start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, busy_cnt, WIDTH);
    chk({tag, "_done_cycle"}, done_at, WIDTH + 1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_diff_held"}, mid_d, prev_d);
    chk({tag, "_bor_held"}, mid_b, prev_b);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_borrow"}, borrow_out, exp_b);
  endtask

  initial begin
    int done_idx[$];
    int busy_cnt;
    int done_cnt;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    rst = 1'b0;
    @(negedge clk);

    op("sub_35_12", 8'h35, 8'h12, 8'h23, 1'b0, 0);
    op("sub_12_35", 8'h12, 8'h35, 8'hDD, 1'b1, 0);
    op("sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 0);
    op("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 0);
    op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 0);
    op("sub_ignore_start", 8'h35, 8'h12, 8'h23, 1'b0, 3);

    // Asynchronous abort in the middle of RUN cycle 4.
    @(negedge clk);
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
    @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    chk("abort_no_busy", busy_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 0);

    // Start held high: a new operation every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy && done) chk("cont_exclusive", {busy, done}, 2'b00);
      if (done) begin
        done_idx.push_back(i);
        chk("cont_diff", diff, 8'h0F);
        chk("cont_borrow", borrow_out, 0);
      end
    end
    start = 1'b0;
    chk("cont_done_count", done_idx.size(), 4);
    if (done_idx.size() > 0) chk("cont_first_done", done_idx[0], WIDTH);
    for (int j = 1; j < done_idx.size(); j++)
      chk("cont_spacing", done_idx[j] - done_idx[j-1], WIDTH + 2);
    repeat (WIDTH + 3) @(negedge clk);
    chk("final_idle_busy", busy, 0);
    chk("final_idle_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial N-bit subtractor controller; computes diff = a - b, one bit per clock, LSB first.
- Drives a single 1-bit full-subtractor slice, which it instantiates.
- Sequences the slice with a start/busy/done handshake and registers the result.
- Sits beside the combinational subtractor blocks as the area-cheap multi-bit option.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered difference, a - b mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, bit counter and borrow flop all cleared.
  - Reset during RUN aborts the operation; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Load a_sh<=a, b_sh<=b, res_sh<=0, bor<=0, cnt<=0.
  - Next state RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Slice inputs: x=a_sh[0], y=b_sh[0], bin=bor.
  - Slice outputs: d = x^y^bin; bo = (~x&y) | (~(x^y)&bin).
  - a_sh, b_sh shift right 1.
  - res_sh shifts right with d inserted at MSB.
  - bor<=bo; cnt<=cnt+1.
- RUN, exit condition: at the edge where cnt==WIDTH-1:
  - Next state DONE.
  - Final result commits: diff<=completed res_sh (including this edge's d); borrow_out<=bo.
- DONE: done=1 for exactly one cycle; unconditional return to IDLE on the next edge.
- Timing:
  - busy high for exactly WIDTH cycles, edges k+1..k+WIDTH.
  - done high in the cycle after edge k+WIDTH.
  - Total latency from the start-accepting edge to done: WIDTH+1 cycles.
- start handling outside IDLE:
  - Ignored in RUN and DONE, with no queuing.
  - Operand changes during RUN have no effect.
  - A start held high through DONE is accepted on the first IDLE edge, so back-to-back operations have a 1-cycle IDLE gap minimum.
- diff and borrow_out:
  - Hold their value from the DONE entry until the next DONE entry or reset.
  - Do not change during RUN.
- Wrap-around: the result is modulo 2^WIDTH; borrow_out is the only underflow indication.
- Counter: never exceeds WIDTH-1; cleared on acceptance.
- busy and done are mutually exclusive, and both are registered/state-decoded with no combinational path from start.

Decomposition:
- Shared package sub_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default width constant SUB_WIDTH_DEF=8.
- Sub-module full_subtractor_bit:
  - Combinational; ports x, y, bin, d, bo.
  - Built from two Half_Subractor instances plus an OR on the borrows.
  - Reuses the existing half-subtractor block, so the serial path and the combinational path share one verified cell.
- Top serial_sub_ctrl: FSM, counter, shift registers, borrow flop, output registers.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, start pulse:
  - busy high 8 cycles, done high on cycle 9.
  - diff=0x23, borrow_out=0.
- WIDTH=8, a=0x12, b=0x35 -> diff=0xDD, borrow_out=1; and a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
- WIDTH=8, a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; then a=0x00, b=0x00 -> diff=0x00, borrow_out=0, with the previous result held until the new done.
- Start 0x35-0x12; at RUN cycle 3 pulse start with a=0x01, b=0x01 and change a/b:
  - Second start is ignored.
  - Result still 0x23, and exactly one done pulse occurs.
- Start 0x80-0x01; assert rst asynchronously mid-cycle at RUN cycle 4:
  - busy, done, diff and borrow_out go to 0 immediately.
  - No done pulse follows.
  - A fresh start yields diff=0x7F, borrow_out=0.
- Hold start high continuously for 0x10-0x01:
  - Operations repeat every WIDTH+2=10 cycles.
  - Each produces diff=0x0F with a single-cycle done pulse.
